// File: rtl/serial_add4.sv
// Bit-serial adder: {Cout,Sum} = A + B + Cin computed LSB first, one bit per clock.
// Define SERIAL_ADD4_OVF_EN to add the Ovf output (signed two's-complement overflow).
module serial_add4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
`ifdef SERIAL_ADD4_OVF_EN
   output logic             Ovf,
`endif
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic             c_reg, c_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] res_reg, res_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic             cout_reg, cout_next;
   logic             sum_bit, carry_bit;
`ifdef SERIAL_ADD4_OVF_EN
   logic             ovf_reg, ovf_next;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         c_reg     <= 1'b0;
         cnt_reg   <= '0;
         res_reg   <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
`ifdef SERIAL_ADD4_OVF_EN
         ovf_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         c_reg     <= c_next;
         cnt_reg   <= cnt_next;
         res_reg   <= res_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
`ifdef SERIAL_ADD4_OVF_EN
         ovf_reg   <= ovf_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      c_next     = c_reg;
      cnt_next   = cnt_reg;
      res_next   = res_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
`ifdef SERIAL_ADD4_OVF_EN
      ovf_next   = ovf_reg;
`endif
      sum_bit    = a_reg[0] ^ b_reg[0] ^ c_reg;
      carry_bit  = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

      case (state_reg)
         IDLE, DONE: begin
            // DONE behaves like IDLE for a new request, so back-to-back starts lose no cycle.
            state_next = IDLE;
            if (start) begin
               a_next     = A;
               b_next     = B;
               c_next     = Cin;
               cnt_next   = '0;
               state_next = ADD;
            end
         end
         ADD: begin
            a_next   = a_reg >> 1;
            b_next   = b_reg >> 1;
            c_next   = carry_bit;
            res_next = {sum_bit, res_reg[WIDTH-1:1]};
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
               // Final bit: publish the completed result together with the carry-out.
               state_next = DONE;
               sum_next   = {sum_bit, res_reg[WIDTH-1:1]};
               cout_next  = carry_bit;
`ifdef SERIAL_ADD4_OVF_EN
               ovf_next   = c_reg ^ carry_bit;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign Sum  = sum_reg;
   assign Cout = cout_reg;
`ifdef SERIAL_ADD4_OVF_EN
   assign Ovf  = ovf_reg;
`endif
   assign busy = (state_reg == ADD);
   assign done = (state_reg == DONE);

endmodule

// File: doc/serial_add4.md
SERIAL_ADD4 -- requirements
Module: serial_add4

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal 2..16).
REQ-002 clk  input  1  rising-edge clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled on each rising clk edge.
REQ-005 A  input  WIDTH  operand A; sampled only on an accepted start.
REQ-006 B  input  WIDTH  operand B; sampled only on an accepted start.
REQ-007 Cin  input  1  carry-in; sampled only on an accepted start.
REQ-008 Sum  output  WIDTH  registered sum; valid while done=1, then held.
REQ-009 Cout  output  1  registered carry-out; same validity as Sum.
REQ-010 busy  output  1  high while in ADD.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, ADD and DONE.
REQ-013 IDLE with start=1 SHALL accept: latch A, B and Cin into internal shift/carry registers, clear bit counter, go to ADD.
REQ-014 ADD SHALL process one bit per cycle, LSB first: sum bit = a^b^c, carry = majority(a,b,c); sum bit shifts into the result register from the MSB end.
REQ-015 ADD SHALL last exactly WIDTH cycles, then go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: start accepted at edge N -> done=1 in the cycle after edge N+WIDTH; 4 ADD cycles for WIDTH=4.
REQ-018 Sum and Cout SHALL update only on entry to DONE, both simultaneously, and hold until the next entry to DONE or reset.
REQ-019 {Cout,Sum} SHALL equal A+B+Cin (WIDTH+1-bit result) of the accepted operands, for all 2^(2*WIDTH+1) input combinations.
REQ-020 start=1 during ADD SHALL be ignored: no re-latch, no extra done pulse.
REQ-021 start=1 during DONE SHALL be accepted exactly as in IDLE (next state ADD); done still pulses that cycle.
REQ-022 Changes on A, B or Cin after acceptance SHALL NOT affect the result in progress.
REQ-023 busy=1 exactly when state=ADD; done=1 exactly when state=DONE; never both.

Reset
REQ-024 reset=1 SHALL force IDLE, clear the counter and operand/carry registers, and set Sum=0, Cout=0, busy=0, done=0 on the next edge.
REQ-025 reset SHALL take priority over start in the same cycle.
REQ-026 reset during ADD SHALL abort the operation: no done pulse, results cleared.

Configuration
REQ-027 Macro SERIAL_ADD4_OVF_EN SHALL add output Ovf (1 bit) when defined.
REQ-028 With the macro defined: Ovf = signed two's-complement overflow (carry into MSB XOR carry out of MSB), updated and held with Sum, reset to 0.
REQ-029 Without the macro: no Ovf port and no overflow logic; all other behaviour identical.

Verification
REQ-030 Reset, then A=4'hF, B=4'h0, Cin=1, start 1 cycle -> busy high 4 cycles, then done 1 cycle with Sum=4'h0, Cout=1.
REQ-031 Exhaustive sweep: A 0..15, B 0..15, Cin 0..1 (512 vectors), one start per done -> {Cout,Sum} == A+B+Cin every time; stop at first mismatch.
REQ-032 A=3, B=5, Cin=0 accepted; start held with A=F, B=F during ADD -> single done, Sum=4'h8, Cout=0.
REQ-033 A=9, B=7 accepted; reset asserted in 2nd ADD cycle -> idle next cycle, no done, Sum=0, Cout=0, busy=0.
REQ-034 start held continuously with A=1, B=1, Cin=0 -> done every 5th cycle, Sum=4'h2 each time; with SERIAL_ADD4_OVF_EN, A=7, B=1 -> Sum=4'h8, Ovf=1, Cout=0.
